// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared FSM encoding, gray width and RGB565 field positions for cam_capture
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } cam_state_t;

    localparam int GRAY_W = 4;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    // Y = R5 + G6 + B5 peaks at 125, so 7 bits never overflow; gray keeps the top nibble.
    function automatic logic [GRAY_W-1:0] rgb565_to_gray(input logic [15:0] px);
        logic [6:0] y;
        y = 7'(px[R_HI:R_LO]) + 7'(px[G_HI:G_LO]) + 7'(px[B_HI:B_LO]);
        return GRAY_W'(y >> 3);
    endfunction

endpackage

// File: rtl/cam_buf.sv
// rtl/cam_buf.sv - DEPTH x DW pixel RAM, one synchronous write port and one registered read port
module cam_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera frame grabber: syncs the sensor bus, builds RGB565 pixels, stores 4-bit gray
module cam_capture
    import cam_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk,
    input  logic [7:0]        data,
    input  logic              start,
    output logic              busy,
    output logic              ready,
    output logic [AW:0]       pix_count,
    input  logic [AW-1:0]     rd_addr,
    output logic [GRAY_W-1:0] rd_data
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // All camera lines share one synchronizer chain so they stay aligned to each other.
    logic [10:0] sync1;
    logic [10:0] sync2;
    logic        s_vsync;
    logic        s_href;
    logic        s_pclk;
    logic [7:0]  s_data;
    logic        pclk_d;
    logic        vsync_d;
    logic        pclk_edge;
    logic        vsync_rise;
    logic        vsync_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            sync1   <= {vsync, href, pclk, data};
            sync2   <= sync1;
            pclk_d  <= s_pclk;
            vsync_d <= s_vsync;
        end
    end

    assign s_vsync    = sync2[10];
    assign s_href     = sync2[9];
    assign s_pclk     = sync2[8];
    assign s_data     = sync2[7:0];
    assign pclk_edge  = s_pclk & ~pclk_d;
    assign vsync_rise = s_vsync & ~vsync_d;
    assign vsync_fall = ~s_vsync & vsync_d;

    logic       phase_low;
    logic [7:0] hi_byte;
    logic [7:0] lo_byte;
    logic       pix_valid;

    // Dropping href forgets a pending high byte, so the next line starts paired correctly.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_low <= 1'b0;
            hi_byte   <= '0;
            lo_byte   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (!s_href) begin
                phase_low <= 1'b0;
            end else if (pclk_edge) begin
                if (!phase_low) begin
                    hi_byte   <= s_data;
                    phase_low <= 1'b1;
                end else begin
                    lo_byte   <= s_data;
                    phase_low <= 1'b0;
                    pix_valid <= 1'b1;
                end
            end
        end
    end

    cam_state_t state;
    cam_state_t state_next;
    logic       wr_en;
    logic       arm_req;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_ARM;
            ST_ARM:           if (s_vsync) state_next = ST_WAIT_FRAME;
            ST_WAIT_FRAME:    if (vsync_fall) state_next = ST_CAPTURE;
            ST_CAPTURE:       if (pix_count == FULL_COUNT || vsync_rise) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    assign arm_req = start && (state == ST_IDLE || state == ST_DONE);
    assign wr_en   = !reset && pix_valid && (state == ST_CAPTURE) && (pix_count < FULL_COUNT);
    assign busy    = (state == ST_ARM) || (state == ST_WAIT_FRAME) || (state == ST_CAPTURE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            pix_count <= '0;
        end else begin
            state <= state_next;
            if (arm_req) begin
                ready     <= 1'b0;
                pix_count <= '0;
            end else if (wr_en) begin
                pix_count <= pix_count + 1'b1;
            end
            if (state == ST_CAPTURE && state_next == ST_DONE) begin
                ready <= 1'b1;
            end
        end
    end

    cam_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (GRAY_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (pix_count[AW-1:0]),
        .wr_data (rgb565_to_gray({hi_byte, lo_byte})),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - self-checking bench for cam_capture against a frame-level buffer model
module tb_cam_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          href;
    logic          pclk;
    logic [7:0]    data;
    logic          start;
    logic          busy;
    logic          ready;
    logic [AW:0]   pix_count;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;

    int total = 0;
    int bad   = 0;
    int model_mem [DEPTH];
    int mon_busy      = 0;
    int busy_low_seen = 0;

    always #5 clk = ~clk;

    cam_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .href      (href),
        .pclk      (pclk),
        .data      (data),
        .start     (start),
        .busy      (busy),
        .ready     (ready),
        .pix_count (pix_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    function automatic int ref_gray(input int px);
        int r, g, b;
        r = (px >> 11) & 31;
        g = (px >> 5) & 63;
        b = px & 31;
        return (r + g + b) / 8;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mon_busy != 0 && ready !== 1'b1 && busy !== 1'b1) busy_low_seen++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        pclk = 1'b0;
        data = b;
        tick(4);
        pclk = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int px[$]);
        href = 1'b1;
        foreach (px[i]) begin
            send_byte(8'(px[i] >> 8));
            send_byte(8'(px[i]));
        end
        pclk = 1'b0;
        tick(4);
        href = 1'b0;
        tick(4);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick(8);
        vsync = 1'b0;
        tick(8);
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        tick(8);
        vsync = 1'b0;
        tick(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic capture_frame(input int px[$]);
        pulse_start();
        vsync_pulse();
        send_line(px);
        end_frame();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic model_frame(input int px[$]);
        for (int i = 0; i < px.size() && i < DEPTH; i++) model_mem[i] = ref_gray(px[i]);
    endtask

    task automatic read_addr(input int a, output logic [3:0] v);
        rd_addr = AW'(a);
        tick(1);
        v = rd_data;
    endtask

    task automatic random_pixels(input int n, output int px[$]);
        px = {};
        for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 65535)));
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; vsync = 1'b0; href = 1'b0; pclk = 1'b0;
        data = 8'h00; rd_addr = '0;
        tick(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (pix_count !== 5'd0) begin bad++; $display("FAIL reset_pix_count: got %0d want 0", pix_count); end
        total++; if (rd_data !== 4'd0) begin bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        reset = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        int px[$];
        bit ok;
        logic [3:0] v;
        px = {};
        for (int i = 0; i < DEPTH; i++) px.push_back(16'hFFFF);
        capture_frame(px);
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_ready_timeout: got 0 want 1"); end
        total++; if (pix_count !== 5'd16) begin bad++; $display("FAIL full_pix_count: got %0d want 16", pix_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy: got %b want 0", busy); end
        for (int a = 0; a < DEPTH; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'd15) begin bad++; $display("FAIL full_rd[%0d]: got %0d want 15", a, v); end
        end
        model_frame(px);
    endtask

    task automatic test_gray_patterns();
        int px[$];
        int expv[4];
        bit ok;
        logic [3:0] v;
        px = {16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        expv = '{0, 3, 7, 3};
        capture_frame(px);
        wait_ready(ok);
        total++; if (!ok || pix_count !== 5'd4) begin bad++; $display("FAIL gray_pix_count: got %0d want 4", pix_count); end
        for (int a = 0; a < 4; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(expv[a])) begin bad++; $display("FAIL gray_rd[%0d]: got %0d want %0d", a, v, expv[a]); end
        end
        for (int a = 4; a < DEPTH; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL gray_keep[%0d]: got %0d want %0d", a, v, model_mem[a]); end
        end
        model_frame(px);
    endtask

    task automatic test_short_frame();
        int px[$];
        bit ok;
        logic [3:0] v;
        random_pixels(10, px);
        capture_frame(px);
        wait_ready(ok);
        model_frame(px);
        total++; if (!ok || ready !== 1'b1) begin bad++; $display("FAIL short_ready: got %b want 1", ready); end
        total++; if (pix_count !== 5'd10) begin bad++; $display("FAIL short_pix_count: got %0d want 10", pix_count); end
        for (int a = 0; a < DEPTH; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL short_rd[%0d]: got %0d want %0d", a, v, model_mem[a]); end
        end
    endtask

    task automatic test_arm_mid_frame();
        int junk[$];
        int px[$];
        bit ok;
        logic [3:0] v;
        random_pixels(3, junk);
        random_pixels(5, px);
        pulse_start();
        send_line(junk);
        total++; if (pix_count !== 5'd0) begin bad++; $display("FAIL arm_no_write: got %0d want 0", pix_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arm_busy: got %b want 1", busy); end
        vsync_pulse();
        send_line(px);
        end_frame();
        wait_ready(ok);
        model_frame(px);
        total++; if (!ok || pix_count !== 5'd5) begin bad++; $display("FAIL arm_pix_count: got %0d want 5", pix_count); end
        for (int a = 0; a < DEPTH; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL arm_rd[%0d]: got %0d want %0d", a, v, model_mem[a]); end
        end
    endtask

    task automatic test_start_ignored();
        int p1[$];
        int p2[$];
        int all[$];
        bit ok;
        logic [3:0] v;
        random_pixels(4, p1);
        random_pixels(4, p2);
        pulse_start();
        vsync_pulse();
        busy_low_seen = 0;
        mon_busy = 1;
        send_line(p1);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        total++; if (pix_count !== 5'd4) begin bad++; $display("FAIL restart_pix_count: got %0d want 4", pix_count); end
        send_line(p2);
        pulse_start();
        end_frame();
        wait_ready(ok);
        mon_busy = 0;
        total++; if (busy_low_seen != 0) begin bad++; $display("FAIL restart_busy_drop: got %0d low cycles want 0", busy_low_seen); end
        total++; if (!ok || pix_count !== 5'd8) begin bad++; $display("FAIL restart_final_count: got %0d want 8", pix_count); end
        all = {p1, p2};
        model_frame(all);
        for (int a = 0; a < 8; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL restart_rd[%0d]: got %0d want %0d", a, v, model_mem[a]); end
        end
    endtask

    task automatic test_orphan_byte();
        int px[$];
        bit ok;
        logic [3:0] v;
        random_pixels(3, px);
        pulse_start();
        vsync_pulse();
        href = 1'b1;
        send_byte(8'(int'($urandom_range(0, 255))));
        pclk = 1'b0;
        tick(4);
        href = 1'b0;
        tick(4);
        send_line(px);
        end_frame();
        wait_ready(ok);
        model_frame(px);
        total++; if (!ok || pix_count !== 5'd3) begin bad++; $display("FAIL orphan_pix_count: got %0d want 3", pix_count); end
        for (int a = 0; a < 3; a++) begin
            read_addr(a, v);
            total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL orphan_rd[%0d]: got %0d want %0d", a, v, model_mem[a]); end
        end
    endtask

    task automatic test_back_to_back();
        int px[$];
        int n;
        int want;
        bit ok;
        logic [3:0] v;
        for (int f = 0; f < 4; f++) begin
            n = int'($urandom_range(1, 20));
            want = (n < DEPTH) ? n : DEPTH;
            random_pixels(n, px);
            capture_frame(px);
            wait_ready(ok);
            model_frame(px);
            total++; if (!ok || pix_count !== 5'(want)) begin bad++; $display("FAIL b2b%0d_pix_count: got %0d want %0d", f, pix_count, want); end
            for (int a = 0; a < DEPTH; a++) begin
                read_addr(a, v);
                total++; if (v !== 4'(model_mem[a])) begin bad++; $display("FAIL b2b%0d_rd[%0d]: got %0d want %0d", f, a, v, model_mem[a]); end
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        int px[$];
        random_pixels(3, px);
        pulse_start();
        vsync_pulse();
        send_line(px);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        reset = 1'b1;
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", ready); end
        total++; if (pix_count !== 5'd0) begin bad++; $display("FAIL midrst_pix_count: got %0d want 0", pix_count); end
        reset = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_after_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gray_patterns();
        test_short_frame();
        test_arm_mid_frame();
        test_start_ignored();
        test_orphan_byte();
        test_back_to_back();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter DEPTH, default 16: number of pixel slots in the capture buffer.
REQ-002 Parameter AW, default 4: buffer address width; DEPTH SHALL equal 2**AW.
REQ-003 clk  in  1  system clock; the block SHALL use one clock only.
REQ-004 reset  in  1  reset; synchronous and active-high.
REQ-005 vsync  in  1  camera frame sync, asynchronous to clk; high marks the frame blanking interval.
REQ-006 href  in  1  camera line valid, asynchronous to clk.
REQ-007 pclk  in  1  camera pixel clock, sampled as data; it SHALL never clock any flop.
REQ-008 data  in  8  camera byte, valid on pclk rising.
REQ-009 start  in  1  one-cycle arm pulse from the bus slave.
REQ-010 busy  out  1  high while armed or capturing.
REQ-011 ready  out  1  a frame capture is complete and the buffer is stable.
REQ-012 pix_count  out  AW+1  number of pixels written in the last capture.
REQ-013 rd_addr  in  AW  buffer read address.
REQ-014 rd_data  out  4  4-bit gray pixel at rd_addr.

Function
REQ-015 vsync, href, pclk and data SHALL each pass through a 2-flop synchronizer; all four SHALL use equal delay.
REQ-016 A pixel-clock edge SHALL be synced pclk=1 while its previous sample=0; clk SHALL be at least 4x the pclk frequency.
REQ-017 On each edge with synced href=1, the block SHALL latch one byte; the first byte is high (RRRRRGGG) and the second is low (GGGBBBBB), forming RGB565.
REQ-018 The byte-phase toggle SHALL reset to "high" whenever synced href=0, so an orphan half-pixel is discarded.
REQ-019 Gray SHALL be computed as Y = R5 + G6 + B5 (7-bit, no overflow, max 125) with gray = Y[6:3].
REQ-020 The buffer write SHALL occur in the cycle after the low-byte edge, to address pix_count, which then increments.
REQ-021 The FSM SHALL have the states IDLE, ARM, WAIT_FRAME, CAPTURE and DONE.
REQ-022 IDLE or DONE + start -> ARM; ready SHALL clear and pix_count SHALL clear in that same cycle.
REQ-023 ARM -> WAIT_FRAME when synced vsync=1, so a partial frame in progress is never captured.
REQ-024 WAIT_FRAME -> CAPTURE on a synced vsync falling edge.
REQ-025 CAPTURE -> DONE when pix_count reaches DEPTH, or on a synced vsync rising edge (short frame).
REQ-026 On any CAPTURE -> DONE transition, ready SHALL be 1 from the next cycle.
REQ-027 Pixels arriving after DEPTH have been written SHALL be ignored.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 busy SHALL be 1 exactly in the ARM, WAIT_FRAME and CAPTURE states.
REQ-030 rd_data SHALL be registered: it reflects rd_addr with 1-cycle latency in every state.
REQ-031 Reading an address the current capture has not yet written SHALL return the previous contents.
REQ-032 If a read and a write hit the same address in the same cycle, rd_data SHALL return the old value.

Reset
REQ-033 On reset, the FSM SHALL return to IDLE, with busy=0, ready=0, pix_count=0, rd_data=0, the byte phase at "high", and the synchronizers at 0.
REQ-034 Reset mid-capture SHALL abort the capture; buffer contents are not cleared and are undefined until the next ready.

Structure
REQ-035 A shared package cam_pkg SHALL hold the FSM state encoding, the gray-width constant (4) and the RGB565 field positions.
REQ-036 The storage SHALL be one sub-module, cam_buf: a DEPTH x 4 RAM with one synchronous write port and one registered read port.

Verification
REQ-037 Reset, then a vsync pulse with 16 pixels of 0xFFFF -> after start: ready=1, pix_count=16, and every address reads 15.
REQ-038 Pixel sequence 0x0000, 0xF800, 0x07E0, 0x001F at addresses 0-3 -> rd_data 0, 3, 7, 3.
REQ-039 Line of 10 pixels, then a vsync rise -> DONE with pix_count=10 and ready=1.
REQ-040 start asserted while vsync=0 mid-frame -> no write occurs until after the next full vsync pulse.
REQ-041 A second start in CAPTURE -> ignored, and busy stays 1 through to DONE.
REQ-042 href dropping after a high byte -> that byte is discarded and the next pixel pairs correctly; reset asserted mid-CAPTURE -> ready=0, busy=0 on the next cycle.
